// File: rtl/fir_channel_scheduler.sv
// Round-robin L/R time-sharing of one pipelined FIR, in-order tag return to TX; `FIR_BYPASS_EN adds BYPASS.
// Latency: RX strobe to FIR_IN_VALID >= 2 edges; FIR_OUT_VALID to TX_UPDATE 1 edge.
// Backpressure: 1 sample held per channel while FIR_IN_READY=0 or MAX_INFLIGHT tags out; a newer sample overwrites and flags OVERRUN.

module sched_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_rdy,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push_vld && (count != CNT_W'(DEPTH));
    assign do_pop   = pop_rdy && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge mclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

module fir_channel_scheduler #(
    parameter int DATA_W       = 24,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              MCLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] LEFT_RX,
    input  logic              LEFT_RX_READY,
    input  logic [DATA_W-1:0] RIGHT_RX,
    input  logic              RIGHT_RX_READY,
    output logic [DATA_W-1:0] FIR_IN,
    output logic              FIR_IN_VALID,
    output logic              FIR_IN_CH,
    input  logic              FIR_IN_READY,
    input  logic [DATA_W-1:0] FIR_OUT,
    input  logic              FIR_OUT_VALID,
`ifdef FIR_BYPASS_EN
    input  logic              BYPASS,
`endif
    output logic [DATA_W-1:0] LEFT_TX,
    output logic [DATA_W-1:0] RIGHT_TX,
    output logic              LEFT_TX_UPDATE,
    output logic              RIGHT_TX_UPDATE,
    output logic [1:0]        OVERRUN,
    output logic              TAG_ERR
);
    localparam int   CNT_W = $clog2(MAX_INFLIGHT) + 1;
    localparam logic CH_L  = 1'b0;
    localparam logic CH_R  = 1'b1;

    logic [DATA_W-1:0] pend_l_dat;
    logic [DATA_W-1:0] pend_r_dat;
    logic              pend_l_vld;
    logic              pend_r_vld;
    logic              last_ch;
    logic              bypass;
    logic [CNT_W-1:0]  tag_cnt;
    logic              tag_head;
    logic              issue_vld;
    logic              issue_ch;
    logic              issue_l;
    logic              issue_r;
    logic              ret_vld;

`ifdef FIR_BYPASS_EN
    assign bypass = BYPASS;
`else
    assign bypass = 1'b0;
`endif

    // Full count blocks issue even if a result pops at the same edge.
    assign issue_vld = !bypass && FIR_IN_READY && (pend_l_vld || pend_r_vld)
                       && (tag_cnt != CNT_W'(MAX_INFLIGHT));
    assign issue_ch  = pend_r_vld && (!pend_l_vld || last_ch == CH_L);
    assign issue_l   = issue_vld && (issue_ch == CH_L);
    assign issue_r   = issue_vld && (issue_ch == CH_R);
    assign ret_vld   = FIR_OUT_VALID && (tag_cnt != '0);

    sched_fifo #(
        .W     (1),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .mclk     (MCLK),
        .rst      (RST),
        .push_vld (issue_vld),
        .push_dat (issue_ch),
        .pop_rdy  (FIR_OUT_VALID),
        .head_dat (tag_head),
        .count    (tag_cnt)
    );

    always_ff @(posedge MCLK) begin
        if (RST) begin
            pend_l_dat      <= '0;
            pend_r_dat      <= '0;
            pend_l_vld      <= 1'b0;
            pend_r_vld      <= 1'b0;
            last_ch         <= CH_R;
            FIR_IN          <= '0;
            FIR_IN_VALID    <= 1'b0;
            FIR_IN_CH       <= 1'b0;
            LEFT_TX         <= '0;
            RIGHT_TX        <= '0;
            LEFT_TX_UPDATE  <= 1'b0;
            RIGHT_TX_UPDATE <= 1'b0;
            OVERRUN         <= 2'b00;
            TAG_ERR         <= 1'b0;
        end else begin
            FIR_IN_VALID <= issue_vld;
            if (issue_vld) begin
                FIR_IN    <= issue_ch ? pend_r_dat : pend_l_dat;
                FIR_IN_CH <= issue_ch;
                last_ch   <= issue_ch;
            end

            if (!bypass && LEFT_RX_READY) begin
                pend_l_dat <= LEFT_RX;
                pend_l_vld <= 1'b1;
                if (pend_l_vld && !issue_l) begin
                    OVERRUN[0] <= 1'b1;
                end
            end else if (issue_l) begin
                pend_l_vld <= 1'b0;
            end

            if (!bypass && RIGHT_RX_READY) begin
                pend_r_dat <= RIGHT_RX;
                pend_r_vld <= 1'b1;
                if (pend_r_vld && !issue_r) begin
                    OVERRUN[1] <= 1'b1;
                end
            end else if (issue_r) begin
                pend_r_vld <= 1'b0;
            end

            LEFT_TX_UPDATE  <= 1'b0;
            RIGHT_TX_UPDATE <= 1'b0;
            if (ret_vld && tag_head == CH_L) begin
                LEFT_TX        <= FIR_OUT;
                LEFT_TX_UPDATE <= 1'b1;
            end
            if (ret_vld && tag_head == CH_R) begin
                RIGHT_TX        <= FIR_OUT;
                RIGHT_TX_UPDATE <= 1'b1;
            end
            // Bypass writes come last so they win over a draining result.
            if (bypass && LEFT_RX_READY) begin
                LEFT_TX        <= LEFT_RX;
                LEFT_TX_UPDATE <= 1'b1;
            end
            if (bypass && RIGHT_RX_READY) begin
                RIGHT_TX        <= RIGHT_RX;
                RIGHT_TX_UPDATE <= 1'b1;
            end

            if (FIR_OUT_VALID && tag_cnt == '0) begin
                TAG_ERR <= 1'b1;
            end
        end
    end
endmodule
